// File: rtl/apb_pkg.sv
// Shared APB definitions: bus width macros, completer FSM states and word geometry.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_pkg;

  typedef enum logic {APB_IDLE, APB_ACCESS} apb_slv_state_e;

  localparam int APB_WORD_BYTES = `APB_DATA_WIDTH / 8;
  localparam int APB_WAIT_W     = 4;

endpackage

// File: rtl/apb_reg_bank.sv
// Word register bank: synchronous clear, one write port, one combinational read port.
module apb_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // DEPTH is a power of two, so every index value addresses a real word.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with a word-addressed register bank, programmable wait states,
// PSLVERR on bad addresses and a sticky master protocol-violation flag.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = `APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = `APB_DATA_WIDTH,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  prot_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = $clog2(APB_WORD_BYTES);
  localparam logic [APB_WAIT_W-1:0] WAIT_INIT = APB_WAIT_W'(WAIT_CYCLES);

  apb_slv_state_e        r_state;
  logic [APB_WAIT_W-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  r_prot_err;

  logic                  w_addr_err;
  logic                  w_ready;
  logic                  w_done;
  logic                  w_we;
  logic                  w_ctrl_chg;
  logic                  w_viol;
  logic [IDX_W-1:0]      w_ridx;
  logic [IDX_W-1:0]      w_widx;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  // Upper address bits only feed the range check, so out-of-range never aliases.
  assign w_ridx     = PADDR[IDX_W+OFF_W-1:OFF_W];
  assign w_widx     = r_addr[IDX_W+OFF_W-1:OFF_W];
  assign w_addr_err = (PADDR[OFF_W-1:0] != '0) ||
                      ((PADDR >> OFF_W) >= ADDR_WIDTH'(DEPTH));

  assign w_ready = (r_state == APB_ACCESS) && (r_cnt == '0);
  assign w_done  = w_ready && PSEL && PENABLE;
  assign w_we    = w_done && r_write && !r_err;

  assign w_ctrl_chg = PSEL && ((PADDR != r_addr) || (PWRITE != r_write) ||
                               (PWDATA != r_wdata));
  assign w_viol     = ((r_state == APB_IDLE) && PSEL && PENABLE) ||
                      ((r_state == APB_ACCESS) && (!PSEL || w_ctrl_chg));

  apb_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_bank (
    .i_clk   (PCLK),
    .i_rst_n (PRESETn),
    .i_we    (w_we),
    .i_waddr (w_widx),
    .i_wdata (r_wdata),
    .i_raddr (w_ridx),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state    <= APB_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_prot_err <= 1'b0;
    end else begin
      if (w_viol) begin
        r_prot_err <= 1'b1;
      end
      case (r_state)
        APB_IDLE: begin
          if (PSEL && !PENABLE) begin
            r_state <= APB_ACCESS;
            r_addr  <= PADDR;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_cnt   <= WAIT_INIT;
            r_err   <= w_addr_err;
            r_rdata <= w_addr_err ? '0 : w_mem_rdata;
          end
        end
        APB_ACCESS: begin
          // A dropped PSEL aborts the transfer; the write enable is already gated off.
          if (!PSEL) begin
            r_state <= APB_IDLE;
          end else if (PENABLE) begin
            if (r_cnt == '0) begin
              r_state <= APB_IDLE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: r_state <= APB_IDLE;
      endcase
    end
  end

  assign PREADY   = w_ready;
  assign PSLVERR  = w_ready && r_err;
  assign PRDATA   = (w_ready && !r_write && !r_err) ? r_rdata : '0;
  assign prot_err = r_prot_err;

endmodule
